// File: rtl/instr_seq_pkg.sv
// instr_seq_pkg: default field widths, packed-word bit offsets, sequencer states and a field-pack helper.
package instr_seq_pkg;
    localparam int PC_W_DEF    = 10;
    localparam int BURST_W_DEF = 3;
    localparam int SEL_W_DEF   = 1;
    localparam int HADDR_W_DEF = 10;
    localparam int DATA_W_DEF  = 8;
    localparam int INSTR_W_DEF = 1 + BURST_W_DEF + SEL_W_DEF + HADDR_W_DEF + DATA_W_DEF;
    localparam int DATA_LSB    = 0;
    localparam int ADDR_LSB    = DATA_LSB + DATA_W_DEF;
    localparam int SEL_LSB     = ADDR_LSB + HADDR_W_DEF;
    localparam int BURST_LSB   = SEL_LSB + SEL_W_DEF;
    localparam int WRITE_BIT   = BURST_LSB + BURST_W_DEF;

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

    function automatic logic [INSTR_W_DEF-1:0] pack_instr(
        input logic                   wr,
        input logic [BURST_W_DEF-1:0] burst,
        input logic [SEL_W_DEF-1:0]   sel,
        input logic [HADDR_W_DEF-1:0] addr,
        input logic [DATA_W_DEF-1:0]  data
    );
        return {wr, burst, sel, addr, data};
    endfunction
endpackage

// File: rtl/instr_sequencer_ram.sv
// instr_ram: single-write, single-read synchronous RAM; the read register clears on rst so outputs start at zero.
module instr_ram #(
    parameter  int W     = 23,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: loadable command RAM walked over a PC window, one command per valid/ready handshake.
// Define INSTR_PARITY_EN to store an even-parity bit per word and expose the sticky par_err output.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter  int PC_W    = 10,
    parameter  int BURST_W = 3,
    parameter  int SEL_W   = 1,
    parameter  int HADDR_W = 10,
    parameter  int DATA_W  = 8,
    localparam int INSTR_W = 1 + BURST_W + SEL_W + HADDR_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [PC_W-1:0]    start_pc,
    input  logic [PC_W-1:0]    end_pc,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic               prog_err,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               cmd_write,
    output logic [BURST_W-1:0] cmd_burst,
    output logic [SEL_W-1:0]   cmd_sel,
    output logic [HADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0]  cmd_data,
    output logic [PC_W-1:0]    pc,
`ifdef INSTR_PARITY_EN
    output logic               par_err,
`endif
    output logic               busy,
    output logic               done
);
`ifdef INSTR_PARITY_EN
    localparam int RAM_W = INSTR_W + 1;
`else
    localparam int RAM_W = INSTR_W;
`endif

    state_t             state_q;
    logic [PC_W-1:0]    pc_q, start_q, end_q;
    logic               valid_q, prog_err_q;
    logic [RAM_W-1:0]   ram_wdata, ram_rdata;
    logic [INSTR_W-1:0] word;
    logic               par_bad, hs, launch;

    assign busy        = state_q == FETCH || state_q == PRESENT;
    assign done        = state_q == DONE;
    assign pc          = pc_q;
    assign prog_err    = prog_err_q;
    assign launch      = start && (state_q == IDLE || state_q == DONE);
    assign word        = ram_rdata[INSTR_W-1:0];
    assign cmd_write   = word[INSTR_W-1];
    assign cmd_burst   = word[INSTR_W-2 -: BURST_W];
    assign cmd_sel     = word[DATA_W+HADDR_W +: SEL_W];
    assign cmd_addr    = word[DATA_W +: HADDR_W];
    assign cmd_data    = word[DATA_W-1:0];
    assign instr_valid = valid_q && !par_bad;
    assign hs          = instr_valid && instr_ready;

`ifdef INSTR_PARITY_EN
    logic par_err_q;
    // The stored word plus its parity bit XORs to zero; a set XOR on read means corruption.
    assign ram_wdata = {^prog_data, prog_data};
    assign par_bad   = state_q == PRESENT && ^ram_rdata;
    assign par_err   = par_err_q;

    always_ff @(posedge clk) begin
        if (rst || (!stop && launch)) par_err_q <= 1'b0;
        else if (!stop && par_bad) par_err_q <= 1'b1;
    end
`else
    assign ram_wdata = prog_data;
    assign par_bad   = 1'b0;
`endif

    instr_ram #(.W(RAM_W), .DEPTH(2 ** PC_W)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wdata (ram_wdata),
        .re    (state_q == FETCH),
        .raddr (pc_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            start_q    <= '0;
            end_q      <= '0;
            valid_q    <= 1'b0;
            prog_err_q <= 1'b0;
        end else begin
            prog_err_q <= prog_we && busy;
            if (stop) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, DONE: if (launch) begin
                        start_q <= start_pc;
                        end_q   <= end_pc;
                        pc_q    <= start_pc;
                        state_q <= FETCH;
                    end
                    FETCH: begin
                        state_q <= PRESENT;
                        valid_q <= 1'b1;
                    end
                    PRESENT: if (par_bad) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                    end else if (hs) begin
                        valid_q <= 1'b0;
                        state_q <= (pc_q == end_q && !loop_en) ? DONE : FETCH;
                        pc_q    <= (pc_q != end_q) ? pc_q + 1'b1 : loop_en ? start_q : pc_q;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized checks of instr_sequencer against a RAM-image model and window-walk reference.
// Covers the INSTR_PARITY_EN build as well when that macro is defined.
module tb_instr_sequencer;
    import instr_seq_pkg::*;
    localparam int PC_W  = 10;
    localparam int IW    = 23;
    localparam int DEPTH = 1024;

    logic            clk = 1'b0;
    logic            rst, start, stop, loop_en, prog_we, instr_ready;
    logic [PC_W-1:0] start_pc, end_pc, prog_addr, pc;
    logic [IW-1:0]   prog_data;
    logic            prog_err, instr_valid, cmd_write, busy, done;
    logic [2:0]      cmd_burst;
    logic [0:0]      cmd_sel;
    logic [9:0]      cmd_addr;
    logic [7:0]      cmd_data;
`ifdef INSTR_PARITY_EN
    logic            par_err;
`endif

    logic [IW-1:0] model [DEPTH];
    int            q_pc[$];
    int            total = 0;
    int            bad = 0;
    int            hs_cnt, cyc_cnt;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .start_pc(start_pc), .end_pc(end_pc), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_err(prog_err), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .cmd_write(cmd_write), .cmd_burst(cmd_burst),
        .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .pc(pc),
`ifdef INSTR_PARITY_EN
        .par_err(par_err),
`endif
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, want finish before 400us");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int a, input logic [IW-1:0] d);
        prog_we = 1'b1;
        prog_addr = PC_W'(a);
        prog_data = d;
        tick();
        prog_we = 1'b0;
        model[a] = d;
    endtask

    task automatic do_start(input int sp, input int ep, input logic lp);
        start_pc = PC_W'(sp);
        end_pc = PC_W'(ep);
        loop_en = lp;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic void build_q(input int sp, input int ep);
        q_pc.delete();
        for (int p = sp; ; p = (p + 1) % DEPTH) begin
            q_pc.push_back(p);
            if (p == ep) break;
        end
    endfunction

    // Every cycle with instr_valid high is compared with the next expected PC and its RAM image word.
    task automatic run_window(input int pct, input int hold_idx, input int hold_n, input int budget);
        int   held = 0;
        logic fire;
        hs_cnt = 0;
        cyc_cnt = 0;
        while (hs_cnt < q_pc.size() && !done && cyc_cnt < budget) begin
            fire = 1'b0;
            if (instr_valid) begin
                total++;
                if (int'(pc) !== q_pc[hs_cnt] ||
                    {cmd_write, cmd_burst, cmd_sel, cmd_addr, cmd_data} !== model[q_pc[hs_cnt]]) begin
                    bad++;
                    $display("FAIL cmd[%0d]: got pc=%0d word=%h, want pc=%0d word=%h", hs_cnt, pc,
                             {cmd_write, cmd_burst, cmd_sel, cmd_addr, cmd_data}, q_pc[hs_cnt], model[q_pc[hs_cnt]]);
                end
                if (hs_cnt == hold_idx && held < hold_n) begin
                    held++;
                    instr_ready = 1'b0;
                end else instr_ready = $urandom_range(99) < pct;
                fire = instr_ready;
            end else instr_ready = 1'b0;
            tick();
            cyc_cnt++;
            if (fire) hs_cnt++;
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; prog_we = 1'b0; instr_ready = 1'b0;
        start_pc = '0; end_pc = '0; prog_addr = '0; prog_data = '0;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({instr_valid, busy, done, prog_err} !== 4'b0 || pc !== '0 ||
            {cmd_write, cmd_burst, cmd_sel, cmd_addr, cmd_data} !== '0) begin
            bad++;
            $display("FAIL reset: valid=%b busy=%b done=%b err=%b pc=%0d cmd=%h, want all zero",
                     instr_valid, busy, done, prog_err, pc, {cmd_write, cmd_burst, cmd_sel, cmd_addr, cmd_data});
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) prog(i, pack_instr(1'b1, 3'd0, 1'b0, 10'(i + 1), 8'(i + 1)));
        build_q(0, 3);
        do_start(0, 3, 1'b0);
        total++;
        if (instr_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_fetch: valid=%b busy=%b, want valid=0 busy=1", instr_valid, busy);
        end
        run_window(100, -1, 0, 100);
        total++;
        if (hs_cnt != 4 || done !== 1'b1 || cyc_cnt != 8) begin
            bad++;
            $display("FAIL basic_run: hs=%0d done=%b cycles=%0d, want hs=4 done=1 cycles=8", hs_cnt, done, cyc_cnt);
        end
    endtask

    task automatic test_backpressure();
        build_q(0, 3);
        do_start(0, 3, 1'b0);
        run_window(100, 1, 5, 100);
        total++;
        if (hs_cnt != 4 || done !== 1'b1 || cyc_cnt != 13) begin
            bad++;
            $display("FAIL backpressure: hs=%0d done=%b cycles=%0d, want hs=4 done=1 cycles=13", hs_cnt, done, cyc_cnt);
        end
    endtask

    task automatic test_wrap();
        foreach (q_pc[i]) q_pc[i] = 0;
        prog(1022, IW'($urandom));
        prog(1023, IW'($urandom));
        prog(0, IW'($urandom));
        prog(1, IW'($urandom));
        build_q(1022, 1);
        do_start(1022, 1, 1'b0);
        run_window(100, -1, 0, 100);
        total++;
        if (hs_cnt != 4 || done !== 1'b1) begin
            bad++;
            $display("FAIL wrap: hs=%0d done=%b, want hs=4 done=1", hs_cnt, done);
        end
    endtask

    task automatic test_loop();
        prog(5, IW'($urandom));
        q_pc.delete();
        for (int i = 0; i < 6; i++) q_pc.push_back(5);
        do_start(5, 5, 1'b1);
        run_window(70, -1, 0, 300);
        total++;
        if (hs_cnt != 6 || done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL loop_repeat: hs=%0d done=%b busy=%b, want hs=6 done=0 busy=1", hs_cnt, done, busy);
        end
        loop_en = 1'b0;
        q_pc.delete();
        q_pc.push_back(5);
        run_window(100, -1, 0, 50);
        total++;
        if (hs_cnt != 1 || done !== 1'b1) begin
            bad++;
            $display("FAIL loop_exit: hs=%0d done=%b, want hs=1 done=1", hs_cnt, done);
        end
    endtask

    task automatic test_stop_prog_err();
        for (int i = 0; i < 4; i++) prog(i, IW'($urandom));
        do_start(0, 3, 1'b0);
        tick();
        prog_we = 1'b1;
        prog_addr = 10'd1;
        prog_data = ~model[1];
        start_pc = 10'd7;
        start = 1'b1;
        tick();
        prog_we = 1'b0;
        start = 1'b0;
        total++;
        if (prog_err !== 1'b1 || instr_valid !== 1'b1 || pc !== 10'd0) begin
            bad++;
            $display("FAIL busy_write: err=%b valid=%b pc=%0d, want err=1 valid=1 pc=0", prog_err, instr_valid, pc);
        end
        instr_ready = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        instr_ready = 1'b0;
        total++;
        if (prog_err !== 1'b0 || instr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pc !== 10'd0) begin
            bad++;
            $display("FAIL stop: err=%b valid=%b busy=%b done=%b pc=%0d, want 0 0 0 0 pc=0",
                     prog_err, instr_valid, busy, done, pc);
        end
        build_q(0, 3);
        do_start(0, 3, 1'b0);
        run_window(80, -1, 0, 200);
        total++;
        if (hs_cnt != 4 || done !== 1'b1) begin
            bad++;
            $display("FAIL rerun: hs=%0d done=%b, want hs=4 done=1", hs_cnt, done);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int sp  = $urandom_range(DEPTH - 1);
            int len = $urandom_range(5);
            for (int i = 0; i <= len; i++) prog((sp + i) % DEPTH, IW'($urandom));
            build_q(sp, (sp + len) % DEPTH);
            do_start(sp, (sp + len) % DEPTH, 1'b0);
            run_window(60, -1, 0, 400);
            total++;
            if (hs_cnt != len + 1 || done !== 1'b1) begin
                bad++;
                $display("FAIL random[%0d]: hs=%0d done=%b, want hs=%0d done=1", n, hs_cnt, done, len + 1);
            end
        end
    endtask

`ifdef INSTR_PARITY_EN
    task automatic test_parity();
        for (int i = 0; i < 4; i++) prog(i, IW'($urandom));
        dut.u_ram.mem[2][0] = ~dut.u_ram.mem[2][0];
        build_q(0, 3);
        do_start(0, 3, 1'b0);
        run_window(100, -1, 0, 100);
        total++;
        if (hs_cnt != 2 || done !== 1'b1 || par_err !== 1'b1) begin
            bad++;
            $display("FAIL parity: hs=%0d done=%b par_err=%b, want hs=2 done=1 par_err=1", hs_cnt, done, par_err);
        end
        prog(2, model[2]);
        do_start(2, 2, 1'b0);
        total++;
        if (par_err !== 1'b0) begin
            bad++;
            $display("FAIL parity_clear: par_err=%b, want 0", par_err);
        end
        build_q(2, 2);
        run_window(100, -1, 0, 50);
        total++;
        if (hs_cnt != 1 || done !== 1'b1) begin
            bad++;
            $display("FAIL parity_rerun: hs=%0d done=%b, want hs=1 done=1", hs_cnt, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_loop();
        test_stop_prog_err();
        test_random();
`ifdef INSTR_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
